// File: rtl/add.sv
// add -- registered unsigned adder with a valid strobe.
//
// Adds two WIDTH-bit unsigned operands. The WIDTH+1-bit result is
// registered, so the carry-out is kept in the MSB. The latency is fixed
// at one cycle, and a new pair can be accepted on every cycle.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst_n      asynchronous, active-low reset; clears sum and out_valid
//   in_valid   the operand pair on a/b is valid this cycle
//   a, b       unsigned operands, WIDTH bits each
//   sum        registered a + b, WIDTH+1 bits; sum[WIDTH] is the carry-out
//   out_valid  sum was updated on the most recent rising edge
//
// Parameters:
//   WIDTH      operand width, legal range 1..32 (default 4)

module add #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   sum,
  output logic             out_valid
);

  // Zero-extend both operands before adding, so the carry lands in
  // bit WIDTH and is not lost to truncation.
  logic [WIDTH:0] sum_next;

  assign sum_next = {1'b0, a} + {1'b0, b};

  // sum only loads on a valid cycle. While in_valid is low, the operand
  // inputs (even X or Z) never reach the register.
  // NOTE: registers are written with non-blocking assignments, so every
  // flop samples its inputs before any of them updates on the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum <= sum_next;
      end
    end
  end

endmodule

// File: tb/tb_add.sv
// tb_add -- self-checking bench for the registered adder (WIDTH = 4).
//
// The bench drives inputs on the falling edge and samples outputs on the
// following falling edge, so every check sits half a cycle after the
// capturing rising edge. Expected values come from plain integer
// arithmetic, never from the DUT.

module tb_add;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH:0]   sum;
  logic             out_valid;

  int tests_run = 0;
  int tests_failed = 0;

  add #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .sum       (sum),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             v;
    logic [WIDTH:0]   exp_sum;
    logic             exp_ov;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive one operand pair at a falling edge. Check the registered
  // result at the next falling edge.
  task automatic apply(input vec_t v, input string name);
    @(negedge clk);
    a        = v.a;
    b        = v.b;
    in_valid = v.v;
    @(negedge clk);
    check({name, ".sum"}, 32'(sum), 32'(v.exp_sum));
    check({name, ".ov"}, 32'(out_valid), 32'(v.exp_ov));
  endtask

  // Stop the run if it never finishes on its own.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t seq[$];
    vec_t edge_cases[$];
    logic [WIDTH:0] model_sum;
    logic           model_ov;

    // Basic sequence, then the hold behaviour.
    seq.push_back('{4'd4, 4'd4, 1'b1, 5'd8,  1'b1});
    seq.push_back('{4'd3, 4'd4, 1'b1, 5'd7,  1'b1});
    seq.push_back('{4'd3, 4'd7, 1'b1, 5'd10, 1'b1});
    seq.push_back('{4'd9, 4'd9, 1'b0, 5'd10, 1'b0});
    seq.push_back('{4'd9, 4'd9, 1'b1, 5'd18, 1'b1});

    edge_cases.push_back('{4'd15, 4'd15, 1'b1, 5'd30, 1'b1});
    edge_cases.push_back('{4'd15, 4'd1,  1'b1, 5'd16, 1'b1});
    edge_cases.push_back('{4'd0,  4'd0,  1'b1, 5'd0,  1'b1});

    // Reset is held with valid operands applied. The outputs must stay
    // cleared on every cycle.
    rst_n    = 1'b0;
    a        = 4'd4;
    b        = 4'd4;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("reset.sum", 32'(sum), 32'd0);
      check("reset.ov", 32'(out_valid), 32'd0);
    end
    rst_n = 1'b1;

    for (int i = 0; i < seq.size(); i++) apply(seq[i], $sformatf("seq%0d", i));

    // Assert reset between edges. The outputs must clear before the next
    // rising edge.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst.sum", 32'(sum), 32'd0);
    check("async_rst.ov", 32'(out_valid), 32'd0);

    // A rising edge passes with in_valid=1 while reset is low. Reset
    // wins, and that pair is not replayed.
    @(negedge clk);
    check("rst_wins.sum", 32'(sum), 32'd0);
    check("rst_wins.ov", 32'(out_valid), 32'd0);
    rst_n    = 1'b1;
    a        = 4'd2;
    b        = 4'd5;
    in_valid = 1'b1;
    @(negedge clk);
    check("post_rst.sum", 32'(sum), 32'd7);
    check("post_rst.ov", 32'(out_valid), 32'd1);

    for (int i = 0; i < edge_cases.size(); i++)
      apply(edge_cases[i], $sformatf("edge%0d", i));

    // Apply all 256 pairs back to back. Each check confirms the previous
    // cycle's pair and that out_valid has no gaps.
    for (int i = 0; i < 256; i++) begin
      a        = 4'(i >> 4);
      b        = 4'(i);
      in_valid = 1'b1;
      @(negedge clk);
      check($sformatf("exh%0d.sum", i), 32'(sum), (i >> 4) + (i & 15));
      check($sformatf("exh%0d.ov", i), 32'(out_valid), 32'd1);
    end

    // Random traffic with gaps, checked against an integer model that
    // holds the last valid total.
    model_sum = 5'(15 + 15);
    model_ov  = 1'b1;
    for (int i = 0; i < 300; i++) begin
      int ra;
      int rb;
      int rv;
      ra       = int'($urandom_range(0, 15));
      rb       = int'($urandom_range(0, 15));
      rv       = int'($urandom_range(0, 1));
      a        = 4'(ra);
      b        = 4'(rb);
      in_valid = rv[0];
      if (rv != 0) model_sum = 5'(ra + rb);
      model_ov = rv[0];
      @(negedge clk);
      check($sformatf("rnd%0d.sum", i), 32'(sum), 32'(model_sum));
      check($sformatf("rnd%0d.ov", i), 32'(out_valid), 32'(model_ov));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
